logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/nand2.sv | 12 +
 rtl/logic_unit_pipe.sv | 109 ++++++++++
 tb/tb_logic_unit_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg -- shared definitions for the NAND-built logic unit.
//   OP_W   : width of the operation select field
//   op_e   : operation encodings OP_AND .. OP_PASS
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOTA = 3'd2,
      OP_XOR  = 3'd3,
      OP_XNOR = 3'd4,
      OP_NAND = 3'd5,
      OP_NOR  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

endpackage

// File: rtl/nand2.sv
// nand2 -- single-bit 2-input NAND, the only gate primitive of the datapath.
//   a, b : inputs
//   y    : ~(a & b)
module nand2 (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = ~(a & b);

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe -- single-stage registered bitwise logic unit with
// valid/ready handshakes on both sides. Every operation is composed from
// nand2 gates, one gate network per bit.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake (in_ready = !out_valid || out_ready)
//   a, b, op             : operands and operation select (logic_unit_pkg::op_e)
//   out_valid/out_ready  : downstream handshake
//   result, zero         : registered result and result==0 flag
//   xfer_count           : wrapping count of completed output transfers
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [CNT_W-1:0] xfer_count
);

   // ---- stage p0: combinational NAND network and op select ----
   logic [WIDTH-1:0] n_ab, n_a, n_b, and_v, or_v, nor_v;
   logic [WIDTH-1:0] x_t1, x_t2, xor_v, xnor_v, pass_v;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         nand2 u_nab  (.a(a[gi]),     .b(b[gi]),     .y(n_ab[gi]));
         nand2 u_na   (.a(a[gi]),     .b(a[gi]),     .y(n_a[gi]));
         nand2 u_nb   (.a(b[gi]),     .b(b[gi]),     .y(n_b[gi]));
         nand2 u_and  (.a(n_ab[gi]),  .b(n_ab[gi]),  .y(and_v[gi]));
         // De Morgan: a | b = nand(~a, ~b)
         nand2 u_or   (.a(n_a[gi]),   .b(n_b[gi]),   .y(or_v[gi]));
         nand2 u_nor  (.a(or_v[gi]),  .b(or_v[gi]),  .y(nor_v[gi]));
         // Classic four-gate XOR sharing the nand(a,b) term
         nand2 u_xt1  (.a(a[gi]),     .b(n_ab[gi]),  .y(x_t1[gi]));
         nand2 u_xt2  (.a(b[gi]),     .b(n_ab[gi]),  .y(x_t2[gi]));
         nand2 u_xor  (.a(x_t1[gi]),  .b(x_t2[gi]),  .y(xor_v[gi]));
         nand2 u_xnor (.a(xor_v[gi]), .b(xor_v[gi]), .y(xnor_v[gi]));
         // Pass is a double inversion so it also flows through the gate network
         nand2 u_pass (.a(n_a[gi]),   .b(n_a[gi]),   .y(pass_v[gi]));
      end
   endgenerate

   logic [WIDTH-1:0] res_p0;
   logic             zero_p0;

   always_comb begin
      res_p0 = pass_v;
      case (op)
         OP_AND:  res_p0 = and_v;
         OP_OR:   res_p0 = or_v;
         OP_NOTA: res_p0 = n_a;
         OP_XOR:  res_p0 = xor_v;
         OP_XNOR: res_p0 = xnor_v;
         OP_NAND: res_p0 = n_ab;
         OP_NOR:  res_p0 = nor_v;
         OP_PASS: res_p0 = pass_v;
         default: res_p0 = pass_v;
      endcase
      zero_p0 = (res_p0 == '0);
   end

   // ---- stage p1: output register and handshake ----
   logic             vld_p1;
   logic [WIDTH-1:0] result_p1;
   logic             zero_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             in_xfer, out_xfer;

   assign in_ready = !vld_p1 || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = vld_p1 && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         result_p1 <= '0;
         zero_p1   <= 1'b1;
         cnt_p1    <= '0;
      end else begin
         if (out_xfer)
            cnt_p1 <= cnt_p1 + CNT_W'(1);
         // A new input wins over draining, so a simultaneous in/out keeps vld high
         if (in_xfer) begin
            vld_p1    <= 1'b1;
            result_p1 <= res_p0;
            zero_p1   <= zero_p0;
         end else if (out_xfer) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign out_valid  = vld_p1;
   assign result     = result_p1;
   assign zero       = zero_p1;
   assign xfer_count = cnt_p1;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe -- self-checking bench for logic_unit_pipe with
// WIDTH=8/CNT_W=16, WIDTH=1/CNT_W=4 and WIDTH=64/CNT_W=4 instances.
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // WIDTH=8 instance
   logic        iv8, ir8, ov8, or8, z8;
   logic [7:0]  a8, b8, res8;
   logic [2:0]  op8;
   logic [15:0] cnt8;

   // WIDTH=1 instance
   logic        iv1, ir1, ov1, or1, z1;
   logic [0:0]  a1, b1, res1;
   logic [2:0]  op1;
   logic [3:0]  cnt1;

   // WIDTH=64 instance
   logic        iv64, ir64, ov64, or64, z64;
   logic [63:0] a64, b64, res64;
   logic [2:0]  op64;
   logic [3:0]  cnt64;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
      .out_valid(ov8), .out_ready(or8), .result(res8), .zero(z8), .xfer_count(cnt8));

   logic_unit_pipe #(.WIDTH(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
      .out_valid(ov1), .out_ready(or1), .result(res1), .zero(z1), .xfer_count(cnt1));

   logic_unit_pipe #(.WIDTH(64), .CNT_W(4)) dut64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .op(op64),
      .out_valid(ov64), .out_ready(or64), .result(res64), .zero(z64), .xfer_count(cnt64));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural reference: plain bitwise operators, masked to w bits
   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
      logic [63:0] r;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = ~a;
         3'd3: r = a ^ b;
         3'd4: r = ~(a ^ b);
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a;
      endcase
      if (w < 64) r = r & ((64'd1 << w) - 64'd1);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
   } vec_t;

   vec_t tbl[10];

   // Handshake reference state for the random WIDTH=8 run
   logic        m_vld, m_z;
   logic [7:0]  m_res;
   logic [15:0] m_cnt;
   logic [15:0] c0;

   initial begin
      tbl[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
      tbl[1] = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0};
      tbl[2] = '{3'd2, 8'hF0, 8'h3C, 8'h0F, 1'b0};
      tbl[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCC, 1'b0};
      tbl[4] = '{3'd4, 8'hF0, 8'h3C, 8'h33, 1'b0};
      tbl[5] = '{3'd5, 8'hF0, 8'h3C, 8'hCF, 1'b0};
      tbl[6] = '{3'd6, 8'hF0, 8'h3C, 8'h03, 1'b0};
      tbl[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0};
      tbl[8] = '{3'd3, 8'hAA, 8'hAA, 8'h00, 1'b1};
      tbl[9] = '{3'd1, 8'hAA, 8'hAA, 8'hAA, 1'b0};

      rst = 1'b1;
      iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
      iv1 = 0; or1 = 1; a1 = 0; b1 = 0; op1 = 0;
      iv64 = 0; or64 = 1; a64 = 0; b64 = 0; op64 = 0;
      tick(); tick();
      rst = 1'b0;

      // Reset state and in_ready after release
      chk("rst_out_valid", 64'(ov8), 64'd0);
      chk("rst_result", 64'(res8), 64'd0);
      chk("rst_zero", 64'(z8), 64'd1);
      chk("rst_count", 64'(cnt8), 64'd0);
      chk("rst_in_ready", 64'(ir8), 64'd1);

      // Back-to-back table with out_ready held high
      or8 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         iv8 = 1'b1; a8 = tbl[k].a; b8 = tbl[k].b; op8 = tbl[k].op;
         tick();
         chk($sformatf("tbl%0d_result", k), 64'(res8), 64'(tbl[k].res));
         chk($sformatf("tbl%0d_zero", k), 64'(z8), 64'(tbl[k].z));
         chk($sformatf("tbl%0d_valid", k), 64'(ov8), 64'd1);
         chk($sformatf("tbl%0d_count", k), 64'(cnt8), 64'(k));
      end
      iv8 = 1'b0;
      tick();
      chk("tbl_drain_count", 64'(cnt8), 64'd10);
      chk("tbl_drain_valid", 64'(ov8), 64'd0);
      chk("tbl_drain_hold", 64'(res8), 64'hAA);

      // Backpressure stall
      do_reset();
      or8 = 1'b0; iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; op8 = 3'd0;
      tick();
      chk("bp_first", 64'(res8), 64'h30);
      c0 = cnt8;
      a8 = 8'h12; b8 = 8'h34; op8 = 3'd1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_in_ready", 64'(ir8), 64'd0);
         tick();
         chk("bp_result_hold", 64'(res8), 64'h30);
         chk("bp_valid_hold", 64'(ov8), 64'd1);
         chk("bp_count_hold", 64'(cnt8), 64'(c0));
      end
      or8 = 1'b1;
      #1;
      chk("bp_release_ready", 64'(ir8), 64'd1);
      tick();
      chk("bp_next_result", 64'(res8), 64'h36);
      chk("bp_next_count", 64'(cnt8), 64'(c0 + 16'd1));
      iv8 = 1'b0;
      tick();
      chk("bp_final_count", 64'(cnt8), 64'(c0 + 16'd2));
      chk("bp_final_valid", 64'(ov8), 64'd0);

      // Reset while a result is stuck, with an input offered
      iv8 = 1'b1; or8 = 1'b0; a8 = 8'hFF; b8 = 8'h0F; op8 = 3'd1;
      tick();
      chk("rs_pre_valid", 64'(ov8), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; iv8 = 1'b0;
      chk("rs_valid", 64'(ov8), 64'd0);
      chk("rs_result", 64'(res8), 64'd0);
      chk("rs_zero", 64'(z8), 64'd1);
      chk("rs_count", 64'(cnt8), 64'd0);
      chk("rs_in_ready", 64'(ir8), 64'd1);

      // Random handshake run on WIDTH=8 against the reference state
      m_vld = 1'b0; m_res = 8'h00; m_z = 1'b1; m_cnt = 16'd0;
      for (int k = 0; k < 300; k++) begin
         logic exp_ir;
         logic [7:0] nr;
         iv8 = 1'($urandom_range(0, 1));
         or8 = 1'($urandom_range(0, 3) != 0);
         a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
         if (($urandom & 7) == 0) b8 = a8;
         #1;
         exp_ir = !m_vld || or8;
         chk("rnd_in_ready", 64'(ir8), 64'(exp_ir));
         nr = 8'(ref_op(op8, 64'(a8), 64'(b8), 8));
         tick();
         if (m_vld && or8) m_cnt = m_cnt + 16'd1;
         if (iv8 && exp_ir) begin
            m_res = nr; m_z = (nr == 8'd0); m_vld = 1'b1;
         end else if (m_vld && or8) begin
            m_vld = 1'b0;
         end
         chk("rnd_valid", 64'(ov8), 64'(m_vld));
         chk("rnd_result", 64'(res8), 64'(m_res));
         chk("rnd_zero", 64'(z8), 64'(m_z));
         chk("rnd_count", 64'(cnt8), 64'(m_cnt));
      end
      iv8 = 1'b0; or8 = 1'b1;

      // WIDTH=1 exhaustive truth table
      do_reset();
      or1 = 1'b1;
      for (int o = 0; o < 8; o++) begin
         for (int v = 0; v < 4; v++) begin
            logic [63:0] e;
            iv1 = 1'b1; op1 = 3'(o); a1 = 1'(v >> 1); b1 = 1'(v);
            e = ref_op(op1, 64'(a1), 64'(b1), 1);
            tick();
            chk($sformatf("w1_op%0d_ab%0d", o, v), 64'(res1), e);
            chk($sformatf("w1_zero_op%0d_ab%0d", o, v), 64'(z1), 64'(e == 64'd0));
         end
      end
      iv1 = 1'b0;
      tick();

      // CNT_W=4 wrap: 15 transfers then one more
      do_reset();
      iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; op1 = 3'd7;
      for (int k = 0; k < 15; k++) tick();
      iv1 = 1'b0;
      tick();
      chk("wrap_15", 64'(cnt1), 64'd15);
      chk("wrap_in_ready", 64'(ir1), 64'd1);
      iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      tick();
      chk("wrap_0", 64'(cnt1), 64'd0);

      // WIDTH=64 random ops, continuous flow
      or64 = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         logic [63:0] e;
         iv64 = 1'b1;
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; op64 = 3'($urandom);
         if (k % 97 == 0) begin b64 = a64; op64 = 3'd3; end
         e = ref_op(op64, a64, b64, 64);
         tick();
         chk("w64_result", res64, e);
         chk("w64_zero", 64'(z64), 64'(e == 64'd0));
      end
      iv64 = 1'b0;
      tick();
      chk("w64_count", 64'(cnt64), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
